alu_arbiter: RTL

- Shares the single combinational ALU between two requesters: 0 = main datapath control, 1 = branch/compare helper.
- Arbitrates round-robin and accepts one operation at a time.
- Drives the ALU from registered operands and returns the registered ALUResult/Zero plus an error flag to the winning requester over a valid/ready handshake.
- Sits between the requesters and the ALU instance; the ALU itself is unchanged.

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/rr_arb2.sv | 41 ++++
 rtl/alu_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU and for the logic that sits in front of it.
//   - ALU_* : ALUControl op codes understood by the ALU
//   - ST_*  : state encodings of the arbiter FSM, and state_t
//   - op_legal() : true for the six op codes the ALU implements
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_OPW = 3;

  localparam logic [ALU_OPW-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_OPW-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_OPW-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_OPW-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_OPW-1:0] ALU_XOR = 3'b011;
  localparam logic [ALU_OPW-1:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    EXEC = ST_EXEC,
    RESP = ST_RESP
  } state_t;

  // 100 and 101 are the only codes the ALU does not decode.
  function automatic logic op_legal(input logic [ALU_OPW-1:0] op);
    logic legal;
    case (op)
      ALU_AND, ALU_OR, ALU_ADD,
      ALU_SUB, ALU_XOR, ALU_SLT: legal = 1'b1;
      default:                   legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant. Purely combinational: the caller owns the
// last_grant register and updates it when a grant is actually consumed.
//   valid      in  2  request valid per requester
//   last_grant in  1  index of the requester served most recently
//   gnt_valid  out 1  some requester is granted
//   gnt_idx    out 1  index of the granted requester (0 when none)
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // Single requester wins outright; on contention the one not served last wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = 1'b0;
    case (valid)
      2'b01: begin
        gnt_valid = 1'b1;
        gnt_idx   = 1'b0;
      end
      2'b10: begin
        gnt_valid = 1'b1;
        gnt_idx   = 1'b1;
      end
      2'b11: begin
        gnt_valid = 1'b1;
        gnt_idx   = ~last_grant;
      end
      default: begin
        gnt_valid = 1'b0;
        gnt_idx   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational ALU between requester 0 (main datapath control)
// and requester 1 (branch/compare helper). One operation in flight at a time:
// IDLE (arbitrate/accept) -> EXEC (ALU evaluates) -> RESP (hold response).
//
// Ports
//   clk, reset_n                 clock (rising edge), async active-low reset
//   req_valid/req_ready  [1:0]   request handshake, bit i = requester i
//   req_a, req_b   [2*WIDTH]     operands, requester i at [i*WIDTH +: WIDTH]
//   req_op         [2*OPW]       ALUControl, requester i at [i*OPW +: OPW]
//   resp_valid/resp_ready [1:0]  response handshake, resp_valid is one-hot
//   resp_result, resp_zero       registered ALUResult / Zero (shared)
//   resp_err                     op code was 100 or 101
//   alu_srca, alu_srcb, alu_ctrl to the ALU (driven from issue registers)
//   alu_result, alu_zero         from the ALU
// -----------------------------------------------------------------------------
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [2*OPW-1:0]   req_op,
  output logic [1:0]         resp_valid,
  input  logic [1:0]         resp_ready,
  output logic [WIDTH-1:0]   resp_result,
  output logic               resp_zero,
  output logic               resp_err,
  output logic [WIDTH-1:0]   alu_srca,
  output logic [WIDTH-1:0]   alu_srcb,
  output logic [OPW-1:0]     alu_ctrl,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_zero
);

  state_t             state_r;
  state_t             state_nxt_s;

  logic               gnt_valid_s;
  logic               gnt_idx_s;
  logic [1:0]         req_ready_s;
  logic               accept_s;
  logic               resp_hs_s;
  logic               op_legal_s;

  logic [WIDTH-1:0]   sel_a_s;
  logic [WIDTH-1:0]   sel_b_s;
  logic [OPW-1:0]     sel_op_s;

  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [OPW-1:0]     op_r;
  logic               gnt_r;
  logic               last_grant_r;

  logic [1:0]         resp_valid_r;
  logic [WIDTH-1:0]   resp_result_r;
  logic               resp_zero_r;
  logic               resp_err_r;

  rr_arb2 u_rr_arb2 (
    .valid      (req_valid),
    .last_grant (last_grant_r),
    .gnt_valid  (gnt_valid_s),
    .gnt_idx    (gnt_idx_s)
  );

  // Only the granted requester sees ready, and only while the ALU is free.
  always_comb begin
    req_ready_s = 2'b00;
    if (state_r == IDLE && gnt_valid_s) begin
      req_ready_s[gnt_idx_s] = 1'b1;
    end else begin
      req_ready_s = 2'b00;
    end
  end

  assign req_ready = req_ready_s;
  assign accept_s  = |(req_valid & req_ready_s);
  // resp_ready of the requester not being served is deliberately ignored.
  assign resp_hs_s = (state_r == RESP) && resp_ready[gnt_r];

  // Operand mux for the granted requester.
  always_comb begin
    sel_a_s  = {WIDTH{1'b0}};
    sel_b_s  = {WIDTH{1'b0}};
    sel_op_s = {OPW{1'b0}};
    if (gnt_idx_s) begin
      sel_a_s  = req_a[2*WIDTH-1:WIDTH];
      sel_b_s  = req_b[2*WIDTH-1:WIDTH];
      sel_op_s = req_op[2*OPW-1:OPW];
    end else begin
      sel_a_s  = req_a[WIDTH-1:0];
      sel_b_s  = req_b[WIDTH-1:0];
      sel_op_s = req_op[OPW-1:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; EXEC always lasts exactly one cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC: begin
        state_nxt_s = RESP;
      end
      RESP: begin
        if (resp_hs_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Issue registers: sampled only at acceptance and held afterwards, so the
  // ALU inputs do not toggle outside EXEC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_r          <= {WIDTH{1'b0}};
      b_r          <= {WIDTH{1'b0}};
      op_r         <= ALU_ADD;
      gnt_r        <= 1'b0;
      last_grant_r <= 1'b1;
    end else if (accept_s) begin
      a_r          <= sel_a_s;
      b_r          <= sel_b_s;
      op_r         <= sel_op_s;
      gnt_r        <= gnt_idx_s;
      last_grant_r <= gnt_idx_s;
    end
  end

  assign op_legal_s = op_legal(op_r);

  // Illegal codes are replaced by ADD so the ALU never reaches its default arm.
  assign alu_srca = a_r;
  assign alu_srcb = b_r;
  assign alu_ctrl = op_legal_s ? op_r : ALU_ADD;

  // Response registers: loaded at the end of EXEC, held until the handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid_r  <= 2'b00;
      resp_result_r <= {WIDTH{1'b0}};
      resp_zero_r   <= 1'b0;
      resp_err_r    <= 1'b0;
    end else if (state_r == EXEC) begin
      resp_valid_r  <= gnt_r ? 2'b10 : 2'b01;
      resp_result_r <= op_legal_s ? alu_result : {WIDTH{1'b0}};
      resp_zero_r   <= op_legal_s ? alu_zero : 1'b0;
      resp_err_r    <= ~op_legal_s;
    end else if (resp_hs_s) begin
      resp_valid_r  <= 2'b00;
    end
  end

  assign resp_valid  = resp_valid_r;
  assign resp_result = resp_result_r;
  assign resp_zero   = resp_zero_r;
  assign resp_err    = resp_err_r;

endmodule
